// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, FSM encoding and GF(2^8) helpers.
// Imported by the key expander; holds no logic of its own.
package aes_pkg;

  localparam int NR = 10;
  localparam int KR_W = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Byte-wide AES forward S-box, purely combinational (zero latency, no flow control).
// Table row r holds outputs for inputs 16r..16r+15, first byte leftmost.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bits [8*(255-b)+7 -: 8]; ~b equals 255-b for a byte.
  assign byte_o = SBOX_TBL[{~byte_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_expander.sv
// On-the-fly AES-128 key schedule: 1-cycle load on begin_round, 1-cycle advance per rkey_en.
// No backpressure: the consumer paces the schedule with rkey_en; misuse sets sticky key_err.
module aes_key_expander #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] cipher_key,
  input  logic         begin_round,
  input  logic         rkey_en,
  input  logic [3:0]   round_num,
  output logic [127:0] round_key,
  output logic [3:0]   key_round,
  output logic         key_ready,
  output logic [127:0] last_key,
  output logic         last_key_valid,
  output logic         key_err
);

  import aes_pkg::*;

  localparam logic [KR_W-1:0] LAST_RND = KR_W'(NR);

  state_e          state_q;
  logic [127:0]    round_key_q;
  logic [127:0]    last_key_q;
  logic [7:0]      rcon_q;
  logic [KR_W-1:0] key_round_q;
  logic            key_ready_q;
  logic            last_key_valid_q;
  logic            key_err_q;

  logic [127:0]    src_d;
  logic [127:0]    key_nxt_d;
  logic [7:0]      rc_d;
  logic [31:0]     rot_d;
  logic [31:0]     sub_d;
  logic [31:0]     t_d;
  logic [31:0]     w0_d, w1_d, w2_d, w3_d;

  // One shared next() datapath: fed by the cipher key on load, else by the current round key.
  assign src_d = begin_round ? cipher_key : round_key_q;
  assign rc_d  = begin_round ? RCON_INIT  : rcon_q;
  assign rot_d = {src_d[23:0], src_d[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (rot_d[8*g +: 8]),
      .byte_o (sub_d[8*g +: 8])
    );
  end

  assign t_d  = sub_d ^ {rc_d, 24'h0};
  assign w0_d = src_d[127:96] ^ t_d;
  assign w1_d = src_d[95:64]  ^ w0_d;
  assign w2_d = src_d[63:32]  ^ w1_d;
  assign w3_d = src_d[31:0]   ^ w2_d;
  assign key_nxt_d = {w0_d, w1_d, w2_d, w3_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      round_key_q      <= '0;
      key_round_q      <= '0;
      key_ready_q      <= 1'b0;
      rcon_q           <= RCON_INIT;
      last_key_q       <= '0;
      last_key_valid_q <= 1'b0;
      key_err_q        <= 1'b0;
    end else if (begin_round) begin
      // A new block always wins, even over a simultaneous rkey_en.
      state_q     <= ST_EXPAND;
      round_key_q <= key_nxt_d;
      rcon_q      <= xtime(RCON_INIT);
      key_round_q <= KR_W'(1);
      key_ready_q <= 1'b1;
      key_err_q   <= 1'b0;
    end else if (rkey_en) begin
      case (state_q)
        ST_EXPAND: begin
          if (round_num != key_round_q) begin
            key_err_q <= 1'b1;
          end
          if (key_round_q < LAST_RND) begin
            round_key_q <= key_nxt_d;
            rcon_q      <= xtime(rcon_q);
            key_round_q <= key_round_q + KR_W'(1);
          end else begin
            last_key_q       <= round_key_q;
            last_key_valid_q <= 1'b1;
            key_ready_q      <= 1'b0;
            key_round_q      <= '0;
            state_q          <= ST_DONE;
          end
        end
        default: key_err_q <= 1'b1;
      endcase
    end
  end

  assign round_key      = round_key_q;
  assign key_round      = key_round_q;
  assign key_ready      = key_ready_q;
  assign last_key       = last_key_q;
  assign last_key_valid = last_key_valid_q;
  assign key_err        = key_err_q;

endmodule
